// File: rtl/msg_window_reg.sv
// DEPTH-deep word window for the SHA-256 message schedule: block load, serial
// shift-in with round tracking, clear and hold. Slot 0 is the oldest word.
module msg_window_reg #(
    parameter int WIDTH  = 32,
    parameter int DEPTH  = 16,
    parameter int ROUNDS = 64,
    localparam int RW    = $clog2(ROUNDS + 1)
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     clear,
    input  logic                     load,
    input  logic [WIDTH*DEPTH-1:0]   block_i,
    input  logic                     shift,
    input  logic [WIDTH-1:0]         word_i,
    output logic [WIDTH*DEPTH-1:0]   window_o,
    output logic [WIDTH-1:0]         head_o,
    output logic [WIDTH-1:0]         tail_o,
    output logic [RW-1:0]            round_o,
    output logic                     full_o,
    output logic                     done_o
);

    logic [WIDTH-1:0] slot_q [DEPTH];
    logic [WIDTH-1:0] slot_d [DEPTH];
    logic [RW-1:0]    round_q;
    logic [RW-1:0]    round_d;
    logic             shift_ok;

    // Shifts stop being accepted once the schedule has produced every word.
    assign shift_ok = shift && (round_q < RW'(ROUNDS));

    always_comb begin
        slot_d  = slot_q;
        round_d = round_q;
        if (clear) begin
            for (int i = 0; i < DEPTH; i++) begin
                slot_d[i] = '0;
            end
            round_d = '0;
        end else if (load) begin
            for (int i = 0; i < DEPTH; i++) begin
                slot_d[i] = block_i[WIDTH*(DEPTH-i)-1 -: WIDTH];
            end
            round_d = RW'(DEPTH);
        end else if (shift_ok) begin
            for (int i = 0; i < DEPTH - 1; i++) begin
                slot_d[i] = slot_q[i+1];
            end
            slot_d[DEPTH-1] = word_i;
            round_d         = round_q + RW'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < DEPTH; i++) begin
                slot_q[i] <= '0;
            end
            round_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                slot_q[i] <= slot_d[i];
            end
            round_q <= round_d;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_pack
            assign window_o[WIDTH*(DEPTH-gi)-1 -: WIDTH] = slot_q[gi];
        end
    endgenerate

    assign head_o  = slot_q[0];
    assign tail_o  = slot_q[DEPTH-1];
    assign round_o = round_q;
    assign full_o  = (round_q >= RW'(DEPTH));
    assign done_o  = (round_q == RW'(ROUNDS));

endmodule

// File: tb/tb_msg_window_reg.sv
// Scoreboard bench for msg_window_reg: default 32x16x64 instance plus a
// 64x4x6 instance; stimulus pushes expected state, monitors pop and compare.
module tb_msg_window_reg;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    // ---------------- instance A: WIDTH=32 DEPTH=16 ROUNDS=64
    logic          a_rst, a_clr, a_ld, a_sh;
    logic [511:0]  a_blk;
    logic [31:0]   a_w;
    logic [511:0]  a_win;
    logic [31:0]   a_head, a_tail;
    logic [6:0]    a_round;
    logic          a_full, a_done;

    msg_window_reg #(.WIDTH(32), .DEPTH(16), .ROUNDS(64)) dut_a (
        .CLK(CLK), .RST(a_rst), .clear(a_clr), .load(a_ld), .block_i(a_blk),
        .shift(a_sh), .word_i(a_w), .window_o(a_win), .head_o(a_head),
        .tail_o(a_tail), .round_o(a_round), .full_o(a_full), .done_o(a_done)
    );

    // ---------------- instance B: WIDTH=64 DEPTH=4 ROUNDS=6
    logic          b_rst, b_clr, b_ld, b_sh;
    logic [255:0]  b_blk;
    logic [63:0]   b_w;
    logic [255:0]  b_win;
    logic [63:0]   b_head, b_tail;
    logic [2:0]    b_round;
    logic          b_full, b_done;

    msg_window_reg #(.WIDTH(64), .DEPTH(4), .ROUNDS(6)) dut_b (
        .CLK(CLK), .RST(b_rst), .clear(b_clr), .load(b_ld), .block_i(b_blk),
        .shift(b_sh), .word_i(b_w), .window_o(b_win), .head_o(b_head),
        .tail_o(b_tail), .round_o(b_round), .full_o(b_full), .done_o(b_done)
    );

    typedef struct {
        string        name;
        logic [511:0] win;
        logic [63:0]  head;
        logic [63:0]  tail;
        logic [7:0]   round;
        logic         full;
        logic         done;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];
    int   checks = 0;
    int   passed = 0;

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Reference state, kept as packed windows with slot 0 in the MSBs.
    logic [511:0] ma_win;
    int           ma_round;
    logic [255:0] mb_win;
    int           mb_round;

    task automatic cyc_a(input string name, input logic rst, input logic clr, input logic ld,
                         input logic sh, input logic [511:0] blk, input logic [31:0] w);
        exp_t e;
        a_rst = rst; a_clr = clr; a_ld = ld; a_sh = sh; a_blk = blk; a_w = w;
        @(posedge CLK);
        if (rst || clr) begin
            ma_win = '0; ma_round = 0;
        end else if (ld) begin
            ma_win = blk; ma_round = 16;
        end else if (sh && ma_round < 64) begin
            ma_win = {ma_win[479:0], w}; ma_round++;
        end
        #1;
        e.name  = name;
        e.win   = ma_win;
        e.head  = {32'd0, ma_win[511 -: 32]};
        e.tail  = {32'd0, ma_win[31:0]};
        e.round = 8'(ma_round);
        e.full  = (ma_round >= 16);
        e.done  = (ma_round == 64);
        q_a.push_back(e);
        a_rst = 0; a_clr = 0; a_ld = 0; a_sh = 0;
    endtask

    task automatic cyc_b(input string name, input logic rst, input logic clr, input logic ld,
                         input logic sh, input logic [255:0] blk, input logic [63:0] w);
        exp_t e;
        b_rst = rst; b_clr = clr; b_ld = ld; b_sh = sh; b_blk = blk; b_w = w;
        @(posedge CLK);
        if (rst || clr) begin
            mb_win = '0; mb_round = 0;
        end else if (ld) begin
            mb_win = blk; mb_round = 4;
        end else if (sh && mb_round < 6) begin
            mb_win = {mb_win[191:0], w}; mb_round++;
        end
        #1;
        e.name  = name;
        e.win   = {256'd0, mb_win};
        e.head  = mb_win[255 -: 64];
        e.tail  = mb_win[63:0];
        e.round = 8'(mb_round);
        e.full  = (mb_round >= 4);
        e.done  = (mb_round == 6);
        q_b.push_back(e);
        b_rst = 0; b_clr = 0; b_ld = 0; b_sh = 0;
    endtask

    // Monitors sample on the falling edge, half a cycle after the command edge.
    always @(negedge CLK) begin
        if (q_a.size() > 0) begin
            exp_t e;
            e = q_a.pop_front();
            chk({"A ", e.name, " window"}, {1'b0, a_win}, {1'b0, e.win});
            chk({"A ", e.name, " head"},   512'(a_head),  512'(e.head));
            chk({"A ", e.name, " tail"},   512'(a_tail),  512'(e.tail));
            chk({"A ", e.name, " round"},  512'(a_round), 512'(e.round));
            chk({"A ", e.name, " full"},   512'(a_full),  512'(e.full));
            chk({"A ", e.name, " done"},   512'(a_done),  512'(e.done));
            $display("A %s: round=%0d full=%0b done=%0b head=%h tail=%h",
                     e.name, a_round, a_full, a_done, a_head, a_tail);
        end
        if (q_b.size() > 0) begin
            exp_t e;
            e = q_b.pop_front();
            chk({"B ", e.name, " window"}, 512'(b_win),   e.win);
            chk({"B ", e.name, " head"},   512'(b_head),  512'(e.head));
            chk({"B ", e.name, " tail"},   512'(b_tail),  512'(e.tail));
            chk({"B ", e.name, " round"},  512'(b_round), 512'(e.round));
            chk({"B ", e.name, " full"},   512'(b_full),  512'(e.full));
            chk({"B ", e.name, " done"},   512'(b_done),  512'(e.done));
            $display("B %s: round=%0d full=%0b done=%0b head=%h tail=%h",
                     e.name, b_round, b_full, b_done, b_head, b_tail);
        end
    end

    logic [511:0] blk_i, blk_x;
    logic [255:0] blk_b;
    exp_t         hand;

    initial begin
        a_rst = 1; a_clr = 0; a_ld = 1; a_sh = 0; a_blk = '1; a_w = '0;
        b_rst = 1; b_clr = 0; b_ld = 0; b_sh = 0; b_blk = '0; b_w = '0;
        ma_win = '0; ma_round = 0; mb_win = '0; mb_round = 0;
        for (int i = 0; i < 16; i++) begin
            blk_i[32*(16-i)-1 -: 32] = 32'(i);
            blk_x[32*(16-i)-1 -: 32] = 32'h1111_1111 * 32'(i + 1);
        end
        blk_b = {64'h0123456789ABCDEF, 64'h1111111122222222,
                 64'h3333333344444444, 64'hFEDCBA9876543210};

        cyc_a("reset beats load 1", 1, 0, 1, 0, '1, 32'h0);
        cyc_a("reset beats load 2", 1, 0, 1, 0, '1, 32'h0);
        cyc_a("block load", 0, 0, 1, 0, blk_i, 32'h0);
        cyc_a("first shift", 0, 0, 0, 1, '0, 32'hA5A5A5A5);
        for (int k = 1; k < 48; k++) cyc_a($sformatf("shift %0d", k + 1), 0, 0, 0, 1, '0, 32'h1000 + 32'(k));
        cyc_a("shift when done", 0, 0, 0, 1, '0, 32'hDEADBEEF);
        cyc_a("hold", 0, 0, 0, 0, '0, 32'h0);
        cyc_a("load+shift", 0, 0, 1, 1, blk_x, 32'hDEADBEEF);
        cyc_a("clear+load", 0, 1, 1, 1, blk_x, 32'hDEADBEEF);
        cyc_a("reload", 0, 0, 1, 0, blk_i, 32'h0);
        for (int k = 0; k < 14; k++) cyc_a($sformatf("to round %0d", 17 + k), 0, 0, 0, 1, '0, 32'h2000 + 32'(k));
        cyc_a("reset at round 30", 1, 0, 0, 1, '0, 32'h5555);
        cyc_a("load before fill", 0, 0, 1, 0, blk_x, 32'h0);
        cyc_a("clear", 0, 1, 0, 0, '0, 32'h0);
        for (int k = 0; k < 16; k++) cyc_a($sformatf("fill %0d", k + 1), 0, 0, 0, 1, '0, 32'h100 + 32'(k));
        cyc_a("hold after fill", 0, 0, 0, 0, '0, 32'h0);

        // Hand-computed end state of the serial fill, independent of the model.
        hand.name = "fill hand"; hand.head = 64'h100; hand.tail = 64'h10F; hand.round = 8'd16;
        chk("A fill head hand",  512'(a_head),  512'(hand.head));
        chk("A fill tail hand",  512'(a_tail),  512'(hand.tail));
        chk("A fill round hand", 512'(a_round), 512'(hand.round));
        chk("A fill full hand",  512'(a_full),  512'(1'b1));

        cyc_b("reset", 1, 0, 0, 0, '0, 64'h0);
        cyc_b("load", 0, 0, 1, 0, blk_b, 64'h0);
        chk("B head is M0 hand", 512'(b_head), 512'(64'h0123456789ABCDEF));
        cyc_b("shift 1", 0, 0, 0, 1, '0, 64'hAAAA_0000_0000_0001);
        cyc_b("shift 2", 0, 0, 0, 1, '0, 64'hAAAA_0000_0000_0002);
        chk("B done hand", 512'(b_done), 512'(1'b1));
        cyc_b("shift ignored", 0, 0, 0, 1, '0, 64'hDEADBEEFDEADBEEF);
        chk("B tail hand", 512'(b_tail), 512'(64'hAAAA_0000_0000_0002));
        cyc_b("clear", 0, 1, 0, 1, blk_b, 64'h0);

        for (int n = 0; n < 10 && (q_a.size() > 0 || q_b.size() > 0); n++) @(posedge CLK);
        checks++;
        if (q_a.size() == 0 && q_b.size() == 0) passed++;
        else $display("FAIL drain: %0d/%0d entries left, expected 0", q_a.size(), q_b.size());
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
